// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// address width and the default reset PC.
package fetch_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, registered IF/ID
// output, branch redirect with stale-response draining.
// Optional macro FETCH_MISALIGN_CHK_EN adds misalign_err and drops unaligned redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  input  logic              ifid_ready,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [31:0]       ifid_instr
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic              misalign_err
`endif
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              redir;
  logic [ADDR_W-1:0] redir_target;
  logic              fire;
  logic              load;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned   = redirect_valid && (redirect_addr[1:0] != 2'b00);
  assign redir        = redirect_valid && !misaligned;
  assign redir_target = redirect_addr;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^redirect_addr[1:0];
  assign redir           = redirect_valid;
  assign redir_target    = {redirect_addr[ADDR_W-1:2], 2'b00};
`endif

  // A new request may only go out once the presented word is gone or leaving.
  assign imem_req  = !reset && (state == ST_REQ) && (!ifid_valid || ifid_ready);
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  assign load      = (state == ST_WAIT) && imem_rvalid && !redir;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else begin
      if (load) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_instr <= imem_rdata;
      end else if (redir || (ifid_valid && ifid_ready)) begin
        ifid_valid <= 1'b0;
      end

      // Redirect wins; a response still in flight must be drained, not used.
      if (redir) begin
        pc <= redir_target;
        case (state)
          ST_REQ:   if (fire) state <= ST_DRAIN;
          ST_WAIT:  state <= imem_rvalid ? ST_REQ : ST_DRAIN;
          ST_DRAIN: if (imem_rvalid) state <= ST_REQ;
          default:  state <= ST_REQ;
        endcase
      end else begin
        case (state)
          ST_REQ:   if (fire) state <= ST_WAIT;
          ST_WAIT:  if (imem_rvalid) begin
                      pc    <= pc + 32'd4;
                      state <= ST_REQ;
                    end
          ST_DRAIN: if (imem_rvalid) state <= ST_REQ;
          default:  state <= ST_REQ;
        endcase
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misaligned;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; misalign checks are compiled
// in only when FETCH_MISALIGN_CHK_EN is defined.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic        ifid_ready;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int checkCount = 0;
  int failCount  = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_ready     (ifid_ready),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic gnt,
                               input logic rvld, input logic [31:0] rdata, input logic rdy);
    redirect_valid = rv;
    redirect_addr  = ra;
    imem_gnt       = gnt;
    imem_rvalid    = rvld;
    imem_rdata     = rdata;
    ifid_ready     = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with every other input asserted: nothing may leak through.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", ifid_valid, 0);
    checkOutput("rst_pc", ifid_pc, 0);
    checkOutput("rst_instr", ifid_instr, 0);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("rst_misalign", misalign_err, 0);
`endif

    // Streaming with zero-wait memory and ready=1.
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000, 1'b1);
    checkOutput("s0_req", imem_req, 1);
    checkOutput("s0_addr", imem_addr, 32'h0);
    tick();
    checkOutput("s0_wait_req", imem_req, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b1);
    tick();
    checkOutput("s0_valid", ifid_valid, 1);
    checkOutput("s0_pc", ifid_pc, 32'h0);
    checkOutput("s0_instr", ifid_instr, 32'hAAAA_0000);
    checkOutput("s1_addr", imem_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB_0004, 1'b1);
    tick();
    checkOutput("s1_gap_valid", ifid_valid, 0);
    tick();
    checkOutput("s1_valid", ifid_valid, 1);
    checkOutput("s1_pc", ifid_pc, 32'h4);

    // Stall for 5 cycles: word held, no new request.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
    checkOutput("stall_req0", imem_req, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", ifid_valid, 1);
      checkOutput("stall_pc", ifid_pc, 32'h4);
      checkOutput("stall_instr", ifid_instr, 32'hBBBB_0004);
      checkOutput("stall_req", imem_req, 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hCCCC_0008, 1'b1);
    checkOutput("resume_req", imem_req, 1);
    checkOutput("resume_addr", imem_addr, 32'h8);
    tick();
    tick();
    checkOutput("s2_valid", ifid_valid, 1);
    checkOutput("s2_pc", ifid_pc, 32'h8);
    checkOutput("s2_instr", ifid_instr, 32'hCCCC_0008);

    // Redirect in WAIT, stale response two cycles later.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wredir_req", imem_req, 0);
    checkOutput("wredir_addr", imem_addr, 32'h100);
    checkOutput("wredir_valid", ifid_valid, 0);
    tick();
    checkOutput("drain_req", imem_req, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drained_valid", ifid_valid, 0);
    checkOutput("drained_req", imem_req, 1);
    checkOutput("drained_addr", imem_addr, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    checkOutput("r100_valid", ifid_valid, 1);
    checkOutput("r100_pc", ifid_pc, 32'h100);
    checkOutput("r100_instr", ifid_instr, 32'h1234_5678);

    // Redirect coinciding with grant enters DRAIN; redirect in DRAIN moves pc only.
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("gredir_req", imem_req, 1);
    checkOutput("gredir_addr0", imem_addr, 32'h104);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("gredir_drain_req", imem_req, 0);
    checkOutput("gredir_addr", imem_addr, 32'h200);
    checkOutput("gredir_valid", ifid_valid, 0);
    applyStimulus(1'b1, 32'h0000_0280, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
    checkOutput("dredir_req", imem_req, 0);
    checkOutput("dredir_addr", imem_addr, 32'h280);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("dredir_out_req", imem_req, 1);
    checkOutput("dredir_out_addr", imem_addr, 32'h280);
    checkOutput("dredir_out_valid", ifid_valid, 0);

`ifndef FETCH_MISALIGN_CHK_EN
    applyStimulus(1'b1, 32'h0000_0303, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("lsb_forced_addr", imem_addr, 32'h300);
    checkOutput("lsb_forced_req", imem_req, 1);
`endif

    // Redirect without grant stays in REQ; then wrap past the top of memory.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_0001, 1'b1);
    checkOutput("top_req", imem_req, 1);
    checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    checkOutput("top_pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("top_instr", ifid_instr, 32'hFFFF_0001);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    tick();
    tick();
    checkOutput("wrap_valid", ifid_valid, 1);
    checkOutput("wrap_pc", ifid_pc, 32'h0);
    checkOutput("wrap_instr", ifid_instr, 32'h0000_0002);
    checkOutput("wrap_next_addr", imem_addr, 32'h4);

    // Redirect in WAIT together with rvalid: data dropped, straight back to REQ.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b1, 32'hBAD1_BAD1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rvredir_valid", ifid_valid, 0);
    checkOutput("rvredir_req", imem_req, 1);
    checkOutput("rvredir_addr", imem_addr, 32'h400);

    // Reset while a request is outstanding; the late response is ignored.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("mrst_valid", ifid_valid, 0);
    checkOutput("mrst_pc", ifid_pc, 32'h0);
    checkOutput("mrst_addr", imem_addr, 32'h0);
    checkOutput("mrst_req", imem_req, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD2_BAD2, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("late_valid", ifid_valid, 0);
    checkOutput("late_req", imem_req, 1);
    checkOutput("late_addr", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHK_EN
    applyStimulus(1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mis_pulse", misalign_err, 1);
    checkOutput("mis_addr", imem_addr, 32'h0);
    tick();
    checkOutput("mis_clear", misalign_err, 0);
    checkOutput("mis_addr2", imem_addr, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port redirect_valid, input, 1, meaning a taken branch/jump from EX.
REQ-005 The block SHALL have port redirect_addr, input, 32, meaning the branch/jump target.
REQ-006 The block SHALL have port imem_req, output, 1, meaning an instruction-memory request.
REQ-007 The block SHALL have port imem_addr, output, 32, meaning the request address.
REQ-008 The block SHALL have port imem_gnt, input, 1, meaning the request is accepted this cycle.
REQ-009 The block SHALL have port imem_rvalid, input, 1, meaning read data is valid this cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32, meaning the instruction word.
REQ-011 The block SHALL have port ifid_valid, output, 1, meaning an instruction is presented to IF/ID.
REQ-012 The block SHALL have port ifid_ready, input, 1, meaning IF/ID accepts the instruction (low = stall).
REQ-013 The block SHALL have port ifid_pc, output, 32, meaning the PC of the presented instruction.
REQ-014 The block SHALL have port ifid_instr, output, 32, meaning the presented instruction.

Function
REQ-015 The FSM SHALL have states REQ (issuing request), WAIT (awaiting rvalid) and DRAIN (discarding a stale response), and at most one request SHALL be outstanding.
REQ-016 In REQ, imem_req SHALL be 1 when the output register is empty or ifid_ready=1; imem_addr=pc and SHALL be held stable until imem_gnt; imem_req & imem_gnt SHALL move the FSM to WAIT.
REQ-017 In WAIT, imem_rvalid SHALL load {pc, imem_rdata} into the output register, set ifid_valid=1 next cycle, update pc<=pc+4 (modulo 2^32, wrapping 0xFFFFFFFC->0) and return to REQ.
REQ-018 ifid_valid & ifid_ready SHALL empty the output register unless it is reloaded in the same cycle; ifid_pc and ifid_instr SHALL stay stable while ifid_valid=1 and ifid_ready=0.
REQ-019 redirect_valid SHALL have highest priority: pc<=redirect_addr, the output register SHALL be invalidated, and no instruction fetched before the redirect SHALL reach ifid_valid.
REQ-020 A redirect in REQ without grant SHALL leave the FSM in REQ; a redirect in REQ with imem_gnt in the same cycle, or in WAIT without rvalid, SHALL move the FSM to DRAIN.
REQ-021 A redirect in WAIT coinciding with imem_rvalid SHALL discard the data and move the FSM to REQ.
REQ-022 In DRAIN, imem_req=0, and imem_rvalid SHALL be discarded and move the FSM to REQ; a further redirect in DRAIN SHALL only update pc.
REQ-023 Best-case throughput SHALL be one instruction per 2 cycles with a zero-wait-state memory; all outputs SHALL be registered except imem_req.

Reset
REQ-024 Reset SHALL set state=REQ, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=0, and force imem_req=0 during the reset cycle.
REQ-025 Reset SHALL override redirect and memory inputs, and a reset mid-request SHALL abandon any outstanding response, which SHALL be ignored unless the FSM is in WAIT.

Configuration
REQ-026 With FETCH_MISALIGN_CHK_EN defined, output misalign_err (1 bit, reset 0) SHALL pulse for one cycle when redirect_valid=1 and redirect_addr[1:0]!=0, and that redirect SHALL be ignored.
REQ-027 Without FETCH_MISALIGN_CHK_EN, the misalign_err port SHALL be absent and redirect_addr[1:0] SHALL be forced to 2'b00.

Structure
REQ-028 Package fetch_pkg SHALL hold the FSM state enum, the default RESET_PC and the 32-bit address width constant.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 Reset release with gnt=rvalid=1 constantly and ready=1 SHALL give ifid_pc sequence 0x0, 0x4, 0x8, with ifid_valid every second cycle.
REQ-031 Holding ready=0 for 5 cycles SHALL hold ifid_pc=0x4 stable with no new imem_req, and resumption SHALL occur at 0x8.
REQ-032 A redirect to 0x100 while in WAIT, with rvalid 2 cycles later, SHALL discard the stale word and make the next ifid_pc=0x100.
REQ-033 A redirect to 0x200 in the same cycle as imem_gnt SHALL enter DRAIN, and the next imem_addr SHALL be 0x200.
REQ-034 A redirect to 0xFFFFFFFC SHALL give ifid_pc=0xFFFFFFFC and then 0x0.
REQ-035 With FETCH_MISALIGN_CHK_EN, a redirect to 0x102 SHALL give a one-cycle misalign_err pulse with pc unchanged.
